throttled_rr_arbiter: RTL
=========================

// Module: throttled_rr_arbiter
// PURPOSE
//   Shares one registered datapath output among N_REQ valid/ready requesters using round-robin with burst locking.
//   A throttle input pauses new grants. The busy/throttle status is exported so a downstream domain-rate adapter can pace itself.
//   Sits between multiple producers and a single clock-domain datapath stage; single clock throughout.
// PARAMETERS
//   N_REQ      4   number of requesters (>=2)
//   WIDTH      8   data width per requester
//   MAX_BURST  4   max consecutive transfers granted to one owner before forced rotation (>=1)
// PORTS
//   i_clk        in   1            clock
//   i_rst        in   1            synchronous reset, active-high
//   i_req_valid  in   N_REQ        per-requester valid
//   i_req_data   in   N_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
//   o_req_ready  out  N_REQ        per-requester ready; at most one bit set per cycle
//   o_dat_valid  out  1            output register holds valid data
//   o_dat        out  WIDTH        output data
//   o_dat_src    out  $clog2(N_REQ) index of requester that produced o_dat
//   i_dat_ready  in   1            downstream accepts o_dat this cycle
//   i_thr        in   1            throttle: 1 = issue no new grant
//   o_thr        out  1            1 when i_thr=1 or owner locked mid-burst (registered)
// BEHAVIOUR
//   - Only one clock. Reset is synchronous and active-high: i_rst sampled on the i_clk rising edge.
//   - Reset: o_dat_valid=0, o_dat=0, o_dat_src=0, o_req_ready=0, o_thr=0, rr pointer=0, burst count=0, state=IDLE.
//   - Transfer in: i_req_valid[k] & o_req_ready[k]. Transfer out: o_dat_valid & i_dat_ready.
//   - Output slot free = !o_dat_valid | i_dat_ready. o_req_ready is combinational: nonzero only when slot free and i_thr=0.
//   - Latency: an accepted request appears on o_dat/o_dat_src the next cycle. Full throughput is 1/cycle.
//   - FSM states:
//     IDLE: owner chosen as first valid requester at or after rr pointer (wrapping N_REQ-1 -> 0).
//       On transfer: go to LOCK, set owner, count=1.
//     LOCK: owner keeps priority while i_req_valid[owner]=1 and count<MAX_BURST. Each transfer does count+1.
//       Exit to IDLE when owner drops valid, or when count reaches MAX_BURST. On exit, rr pointer = owner+1 mod N_REQ.
//   - Rotation on exit is a single-cycle decision. If another requester is valid that same cycle, it may be granted immediately; there are no bubbles.
//   - MAX_BURST=1: LOCK is left after every transfer (pure round-robin).
//   - i_thr=1 in LOCK: no grant, count held, owner kept. Resuming continues the burst.
//   - i_thr=1 does not block draining: o_dat_valid stays until i_dat_ready.
//   - Output stall (o_dat_valid & !i_dat_ready): o_dat, o_dat_src held stable; o_req_ready=0.
//   - Simultaneous drain and accept in one cycle: o_dat_valid stays 1 with new data.
//   - Reset mid-burst: pending output dropped, state to IDLE, pointer to 0.
//   - rr pointer and count widths: $clog2(N_REQ) and $clog2(MAX_BURST+1). Pointer wraps modulo N_REQ.
// CONFIGURATION
//   ARB_STALL_CNT_EN defined: adds output o_stall_cnt[15:0].
//     Counts cycles with o_dat_valid & !i_dat_ready; saturates at 16'hFFFF.
//     Reset to 0; also cleared when i_thr rises (0->1).
//   ARB_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1 Reset with all valid=1 -> o_dat_valid=0, o_req_ready=0; first cycle after reset o_req_ready=4'b0001.
//   2 N_REQ=4, MAX_BURST=4, all valid, i_dat_ready=1 -> o_dat_src sequence 0,0,0,0,1,1,1,1,2... without bubbles.
//   3 Only req2 valid, i_dat_ready=1 -> 4 transfers, then rotation, req2 regranted next cycle; throughput 1/cycle.
//   4 Mid-burst (count=2) with i_thr=1 for 3 cycles -> o_req_ready=0, o_thr=1; after release 2 more req0 transfers, then req1.
//   5 i_dat_ready=0 for 5 cycles with o_dat=8'hA5 -> o_dat stable 8'hA5, o_req_ready=0; with macro o_stall_cnt=5.
//   6 i_rst pulsed during stall -> next cycle o_dat_valid=0, state IDLE, req0 has priority.

Source files
------------

// File: rtl/throttled_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : throttled_rr_arbiter_if
//  Description : Bundle of handshake and bus signals between N_REQ requesters,
//                the throttled round-robin arbiter and the downstream stage.
//                The slave modport is the arbiter's view. The master modport
//                is the view of the surrounding producers and consumer.
//  Ports       : i_req_valid / i_req_data / o_req_ready - requester side
//                o_dat_valid / o_dat / o_dat_src / i_dat_ready - output side
//                i_thr / o_thr - throttle in, throttle/busy status out
//                o_stall_cnt - present only when ARB_STALL_CNT_EN is defined
//  Macro       : ARB_STALL_CNT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
interface throttled_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int c_SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ*WIDTH-1:0] i_req_data;
    logic [N_REQ-1:0]       o_req_ready;
    logic                   o_dat_valid;
    logic [WIDTH-1:0]       o_dat;
    logic [c_SRC_W-1:0]     o_dat_src;
    logic                   i_dat_ready;
    logic                   i_thr;
    logic                   o_thr;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]            o_stall_cnt;
`endif

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_data, i_dat_ready, i_thr,
        output o_req_ready, o_dat_valid, o_dat, o_dat_src, o_thr
`ifdef ARB_STALL_CNT_EN
        , output o_stall_cnt
`endif
    );

    // Producer / consumer side
    modport master (
        output i_req_valid, i_req_data, i_dat_ready, i_thr,
        input  o_req_ready, o_dat_valid, o_dat, o_dat_src, o_thr
`ifdef ARB_STALL_CNT_EN
        , input o_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/throttled_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : throttled_rr_arbiter
//  Description : Round-robin arbiter with burst locking that shares one
//                registered output slot among N_REQ valid/ready requesters.
//                A throttle input pauses new grants. A registered status
//                output reports throttle or mid-burst ownership.
//  Ports       : i_clk  - clock
//                i_rst  - synchronous reset, active-high
//                bus    - throttled_rr_arbiter_if.slave, which carries the
//                         request, output, throttle and status signals
//  Macro       : ARB_STALL_CNT_EN - when defined, bus.o_stall_cnt counts the
//                cycles where the output is stalled. The count saturates and
//                is cleared on a rising edge of i_thr.
//  Revision    : 1.0 - initial release
// ============================================================================
module throttled_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    throttled_rr_arbiter_if.slave bus
);
    localparam int                  c_PTR_W   = $clog2(N_REQ);
    localparam int                  c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0]  c_MAX_CNT = c_CNT_W'(MAX_BURST);
    localparam logic [c_PTR_W-1:0]  c_LAST    = c_PTR_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [c_PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [c_PTR_W-1:0]   owner_q,     owner_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    logic                 dat_valid_q, dat_valid_d;
    logic [WIDTH-1:0]     dat_q,       dat_d;
    logic [c_PTR_W-1:0]   dat_src_q,   dat_src_d;
    logic                 thr_q,       thr_d;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 thr_prev_q;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_slot_free;
    logic                 w_grant_en;
    logic                 w_owner_hold;
    logic [c_PTR_W-1:0]   w_search_base;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_pick;
    logic [WIDTH-1:0]     w_pick_dat;
    logic                 w_xfer;
    logic [c_CNT_W-1:0]   w_new_cnt;
    int                   v_off;
    int                   v_best;

    function automatic logic [c_PTR_W-1:0] f_wrap_inc(input logic [c_PTR_W-1:0] idx);
        return (idx == c_LAST) ? '0 : idx + 1'b1;
    endfunction

    assign w_slot_free  = !dat_valid_q || bus.i_dat_ready;
    assign w_grant_en   = w_slot_free && !bus.i_thr && !i_rst;

    // The owner keeps priority only while it is still valid and has burst
    // budget left. Otherwise the search starts just past the owner. This
    // makes rotation a same-cycle decision with no idle bubble.
    assign w_owner_hold = (state_q == ST_LOCK) && bus.i_req_valid[owner_q]
                          && (cnt_q < c_MAX_CNT);

    always_comb begin : p_base
        w_search_base = rr_ptr_q;
        if (state_q == ST_LOCK) begin
            w_search_base = w_owner_hold ? owner_q : f_wrap_inc(owner_q);
        end
    end

    // Find the first valid requester at or after the search base. The
    // search wraps around. Each candidate is scored by its circular
    // distance from the base, and the smallest distance wins.
    always_comb begin : p_search
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_dat = '0;
        v_best     = N_REQ;
        v_off      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            v_off = k - int'(w_search_base);
            if (v_off < 0) begin
                v_off = v_off + N_REQ;
            end
            if (bus.i_req_valid[k] && (v_off < v_best)) begin
                v_best     = v_off;
                w_found    = 1'b1;
                w_pick     = c_PTR_W'(k);
                w_pick_dat = bus.i_req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer    = w_grant_en && w_found;
    assign w_new_cnt = w_owner_hold ? (cnt_q + 1'b1) : c_CNT_W'(1);

    always_comb begin : p_ready
        bus.o_req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            bus.o_req_ready[k] = w_xfer && (w_pick == c_PTR_W'(k));
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        dat_valid_d = dat_valid_q;
        dat_d       = dat_q;
        dat_src_d   = dat_src_q;

        if (w_xfer) begin
            // This covers load into a free slot and also the case where a
            // drain and an accept happen in the same cycle.
            dat_valid_d = 1'b1;
            dat_d       = w_pick_dat;
            dat_src_d   = w_pick;
            owner_d     = w_pick;
            if (w_new_cnt == c_MAX_CNT) begin
                // The burst budget is used up. Leave now so that the next
                // cycle already searches from the following requester.
                state_d  = ST_IDLE;
                cnt_d    = '0;
                rr_ptr_d = f_wrap_inc(w_pick);
            end else begin
                state_d  = ST_LOCK;
                cnt_d    = w_new_cnt;
            end
        end else begin
            if (bus.i_dat_ready) begin
                dat_valid_d = 1'b0;
            end
            // The owner dropped valid and nobody else was granted. Release
            // the lock. A throttled owner that is still valid keeps it.
            if ((state_q == ST_LOCK) && !w_owner_hold) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                rr_ptr_d = f_wrap_inc(owner_q);
            end
        end

        thr_d = bus.i_thr || (state_d == ST_LOCK);

`ifdef ARB_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
        if (bus.i_thr && !thr_prev_q) begin
            stall_cnt_d = '0;
        end else if (dat_valid_q && !bus.i_dat_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            dat_valid_q <= 1'b0;
            dat_q       <= '0;
            dat_src_q   <= '0;
            thr_q       <= 1'b0;
`ifdef ARB_STALL_CNT_EN
            stall_cnt_q <= '0;
            thr_prev_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            dat_valid_q <= dat_valid_d;
            dat_q       <= dat_d;
            dat_src_q   <= dat_src_d;
            thr_q       <= thr_d;
`ifdef ARB_STALL_CNT_EN
            stall_cnt_q <= stall_cnt_d;
            thr_prev_q  <= bus.i_thr;
`endif
        end
    end

    assign bus.o_dat_valid = dat_valid_q;
    assign bus.o_dat       = dat_q;
    assign bus.o_dat_src   = dat_src_q;
    assign bus.o_thr       = thr_q;
`ifdef ARB_STALL_CNT_EN
    assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
